// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the single GPR write port between in-order writeback (fixed priority)
// and one long-latency SEC source, escalating to a pipeline stall if SEC starves.
module gpr_wport_arbiter #(
   parameter int RF_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wb_valid_i,
   input  logic [RF_ADDR_WIDTH-1:0] wb_rd_i,
   input  logic [DATA_WIDTH-1:0]    wb_wdata_i,
   input  logic                     sec_valid_i,
   output logic                     sec_ready_o,
   input  logic [RF_ADDR_WIDTH-1:0] sec_rd_i,
   input  logic [DATA_WIDTH-1:0]    sec_wdata_i,
   output logic                     stall_o,
   output logic [RF_ADDR_WIDTH-1:0] rd_o,
   output logic [DATA_WIDTH-1:0]    gpr_wdata_o,
   output logic                     gpr_wdata_valid_o
);

   generate
      if (STARVE_LIMIT < 1) begin : g_bad_limit
         $error("gpr_wport_arbiter: STARVE_LIMIT must be >= 1");
      end
   endgenerate

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_sat;
   logic               r_stall;
   logic               w_wb_use;
   logic               w_sec_ready;
   logic               w_handshake;
   logic               w_denied;

   // Writes to x0 are architecturally discarded, so they leave the port free for SEC.
   assign w_wb_use    = wb_valid_i && (wb_rd_i != '0);
   assign w_sec_ready = sec_valid_i && !w_wb_use && !rst_i;
   assign w_handshake = sec_valid_i && w_sec_ready;
   assign w_denied    = sec_valid_i && !w_sec_ready;
   assign w_cnt_sat   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   assign sec_ready_o = w_sec_ready;
   assign stall_o     = r_stall;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_denied) begin
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = (STARVE_LIMIT == 1) ? FORCE : WAIT;
            end
         end
         WAIT: begin
            if (!sec_valid_i || w_handshake) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_sat;
               if (w_cnt_sat == CNT_MAX) w_state_nxt = FORCE;
            end
         end
         FORCE: begin
            if (!sec_valid_i || w_handshake) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_sat;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Stall follows the next state so it rises together with entry into FORCE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stall <= (w_state_nxt == FORCE);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_o              <= '0;
         gpr_wdata_o       <= '0;
         gpr_wdata_valid_o <= 1'b0;
      end else if (w_wb_use) begin
         rd_o              <= wb_rd_i;
         gpr_wdata_o       <= wb_wdata_i;
         gpr_wdata_valid_o <= 1'b1;
      end else if (w_handshake && (sec_rd_i != '0)) begin
         rd_o              <= sec_rd_i;
         gpr_wdata_o       <= sec_wdata_i;
         gpr_wdata_valid_o <= 1'b1;
      end else begin
         rd_o              <= '0;
         gpr_wdata_o       <= '0;
         gpr_wdata_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Directed and randomized bench for gpr_wport_arbiter, checked against a
// cycle-level model that counts consecutive SEC denials as a plain integer.
module tb_gpr_wport_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wbValid;
   logic [AW-1:0] wbRd;
   logic [DW-1:0] wbData;
   logic          secValid;
   logic [AW-1:0] secRd;
   logic [DW-1:0] secData;
   logic          secReady;
   logic          stall;
   logic [AW-1:0] rdOut;
   logic [DW-1:0] dataOut;
   logic          validOut;

   int checks   = 0;
   int failures = 0;

   logic          expValid;
   logic [AW-1:0] expRd;
   logic [DW-1:0] expData;
   logic          expStall;
   int            denials;
   logic          lastHs;

   always #5 clk = ~clk;

   gpr_wport_arbiter #(
      .RF_ADDR_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .wb_valid_i       (wbValid),
      .wb_rd_i          (wbRd),
      .wb_wdata_i       (wbData),
      .sec_valid_i      (secValid),
      .sec_ready_o      (secReady),
      .sec_rd_i         (secRd),
      .sec_wdata_i      (secData),
      .stall_o          (stall),
      .rd_o             (rdOut),
      .gpr_wdata_o      (dataOut),
      .gpr_wdata_valid_o(validOut)
   );

   // Once SEC is pending, its valid and payload must hold until the handshake.
   logic          pendPrev = 1'b0;
   logic [AW-1:0] rdPrev;
   logic [DW-1:0] dataPrev;
   always @(posedge clk) begin
      if (pendPrev && !rst)
         assert (secValid && secRd === rdPrev && secData === dataPrev)
            else $error("FAIL sec_protocol: SEC request changed before handshake");
      pendPrev <= secValid && !secReady && !rst;
      rdPrev   <= secRd;
      dataPrev <= secData;
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                                input logic sv, input logic [AW-1:0] sr, input logic [DW-1:0] sd);
      wbValid  = wv;
      wbRd     = wr;
      wbData   = wd;
      secValid = sv;
      secRd    = sr;
      secData  = sd;
   endtask

   // One clock: check the combinational grant mid-cycle, advance the model, then
   // check the registered outputs just after the edge.
   task automatic stepCycle(input string tag);
      logic wbUse;
      logic hs;
      @(negedge clk);
      wbUse = wbValid && (wbRd != 0);
      hs    = secValid && !wbUse && !rst;
      checkOutput({tag, "_ready"}, DW'(secReady), DW'(hs));
      if (rst) begin
         expValid = 1'b0; expRd = '0; expData = '0; denials = 0;
      end else begin
         if (wbUse) begin
            expValid = 1'b1; expRd = wbRd; expData = wbData;
         end else if (hs && secRd != 0) begin
            expValid = 1'b1; expRd = secRd; expData = secData;
         end else begin
            expValid = 1'b0; expRd = '0; expData = '0;
         end
         if (!secValid || hs) denials = 0;
         else denials++;
      end
      expStall = (denials >= LIMIT);
      lastHs   = hs;
      @(posedge clk);
      #1;
      checkOutput({tag, "_valid"}, DW'(validOut), DW'(expValid));
      checkOutput({tag, "_rd"},    DW'(rdOut),    DW'(expRd));
      checkOutput({tag, "_data"},  dataOut,       expData);
      checkOutput({tag, "_stall"}, DW'(stall),    DW'(expStall));
   endtask

   initial begin
      int            stallAt;
      logic          nSv;
      logic [AW-1:0] nSr;
      logic [DW-1:0] nSd;

      expValid = 1'b0; expRd = '0; expData = '0; expStall = 1'b0; denials = 0; lastHs = 1'b0;
      rst = 1'b1;
      applyStimulus(1'b1, 5'd9, $urandom, 1'b1, 5'd3, $urandom);
      stepCycle("reset0");
      applyStimulus(1'b0, 5'd0, $urandom, 1'b1, 5'd3, $urandom);
      stepCycle("reset1");

      rst = 1'b0;
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
      stepCycle("wb5");
      checkOutput("wb5_explicit_data", dataOut, 32'hDEADBEEF);
      applyStimulus(1'b1, 5'd0, 32'h5555AAAA, 1'b0, 5'd0, 32'h0);
      stepCycle("wb_x0");

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1234);
      stepCycle("sec_idle");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      stepCycle("sec_idle_after");

      applyStimulus(1'b1, 5'd3, 32'hA0A0A0A0, 1'b1, 5'd7, 32'hB7B7B7B7);
      stepCycle("coll1");
      applyStimulus(1'b1, 5'd4, 32'hA1A1A1A1, 1'b1, 5'd7, 32'hB7B7B7B7);
      stepCycle("coll2");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB7B7B7B7);
      stepCycle("coll3");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      stepCycle("coll_idle");

      stallAt = 0;
      for (int i = 1; i <= 12 && stallAt == 0; i++) begin
         applyStimulus(1'b1, AW'(i), $urandom, 1'b1, 5'd9, 32'hCAFE0009);
         stepCycle("starve");
         if (stall === 1'b1) stallAt = i;
      end
      checkOutput("starve_stall_at", DW'(stallAt), DW'(LIMIT));
      applyStimulus(1'b1, 5'd20, 32'h20202020, 1'b1, 5'd9, 32'hCAFE0009);
      stepCycle("inflight_wb");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hCAFE0009);
      stepCycle("starve_grant");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      stepCycle("starve_release");

      for (int i = 1; i <= LIMIT; i++) begin
         applyStimulus(1'b1, AW'(i + 8), $urandom, 1'b1, 5'd14, 32'h0E0E0E0E);
         stepCycle("force_build");
      end
      applyStimulus(1'b1, 5'd17, 32'h17171717, 1'b1, 5'd14, 32'h0E0E0E0E);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_stall", DW'(stall), 32'd0);
      checkOutput("async_valid", DW'(validOut), 32'd0);
      checkOutput("async_ready", DW'(secReady), 32'd0);
      expValid = 1'b0; expRd = '0; expData = '0; expStall = 1'b0; denials = 0;
      #1 rst = 1'b0;
      stepCycle("post_async");
      stallAt = 1;
      for (int i = 2; i <= 12 && stall !== 1'b1; i++) begin
         applyStimulus(1'b1, AW'(i), $urandom, 1'b1, 5'd14, 32'h0E0E0E0E);
         stepCycle("recount");
         stallAt = i;
      end
      checkOutput("recount_stall_at", DW'(stallAt), DW'(LIMIT));
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h0E0E0E0E);
      stepCycle("recount_grant");

      for (int n = 0; n < 400; n++) begin
         if (!secValid || lastHs) begin
            nSv = ($urandom_range(0, 9) < 4);
            nSr = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
            nSd = $urandom;
         end else begin
            nSv = secValid; nSr = secRd; nSd = secData;
         end
         applyStimulus(!expStall && ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
                       $urandom, nSv, nSr, nSd);
         stepCycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
